mnist_image_sequencer: RTL
==========================

Name: mnist_image_sequencer

Overview:
- Hardware initiator for sys_array_wrapper_mnist. It drives the active-low load_params/start_comp pulse protocol and image_num, and waits for ready.
- On each completion it captures the one-hot classes vector, decodes it to a digit (0-9), and stores the digit in an IMAGES-deep result buffer.
- It replaces the manual push-button/testbench sequence when a board runs all stored images unattended. Sits between top-level controls and the wrapper.

Parameters:
- IMAGES, 10, images to run per pass (1..16)
- IDX_W, 4, width of image_num/result index (>= clog2(IMAGES))
- NCLASS, 10, width of classes vector
- GAP_CYCLES, 5, idle cycles between finishing one image and loading the next
- TIMEOUT, 65535, max cycles waiting for ready before abort

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- run  in  1  level; rising edge starts a pass over images 0..IMAGES-1
- load_params  out  1  active-low load pulse to wrapper
- start_comp  out  1  active-low start pulse to wrapper
- image_num  out  IDX_W  image index presented to wrapper
- ready  in  1  wrapper computation-done flag
- classes  in  NCLASS  wrapper one-hot result
- res_valid  out  1  one-cycle strobe, new result captured
- res_idx  out  IDX_W  image index of captured result
- res_digit  out  4  decoded digit; 4'hF when invalid
- res_err  out  1  classes not exactly one-hot at capture
- rd_idx  in  IDX_W  result buffer read address
- rd_digit  out  4  buffer[rd_idx], combinational read
- busy  out  1  pass in progress
- done  out  1  sticky; pass completed; cleared by next run edge
- timeout  out  1  sticky; ready never rose; cleared by next run edge

Behaviour:
- Reset values:
  - load_params = 1, start_comp = 1; image_num, res_idx = 0.
  - res_valid, res_err, busy, done, timeout = 0; res_digit = 4'hF.
  - All buffer entries = 4'hF.
- Edge detection: run and ready are registered (run_q, ready_q). Rise = sig & ~sig_q.
- FSM states: IDLE, LOAD, LGAP, START, WAIT, CAPT, GAP, DONE.
- IDLE: on run rise, go to LOAD. On entry set image_num = 0, busy = 1, clear done/timeout. Run edges while busy are ignored.
- LOAD: load_params = 0 for exactly 1 cycle, then LGAP.
- LGAP: 1 cycle, both pulses high, then START. This matches the wrapper's separated-pulse requirement.
- START: start_comp = 0 for exactly 1 cycle, then WAIT. Clear the wait counter.
- WAIT: leave only on a ready rising edge, so a level left high from the previous image is not accepted. On the rise go to CAPT.
  - The wait counter increments each cycle. When it reaches TIMEOUT: set timeout = 1, busy = 0, go to IDLE. Buffer entries already written are kept.
- CAPT: 1 cycle. Decode classes:
  - Exactly one bit k set: res_digit = k, res_err = 0.
  - Otherwise (zero or multiple bits): res_digit = 4'hF, res_err = 1.
  - Write res_digit to buffer[image_num]. res_idx = image_num. Pulse res_valid for this cycle; res_* hold until the next capture.
  - If image_num == IMAGES-1, go to DONE; else go to GAP.
- GAP: count GAP_CYCLES cycles (GAP_CYCLES = 0 means 1 cycle minimum), increment image_num, then LOAD.
- DONE: set done = 1, busy = 0, image_num stays at IMAGES-1, go to IDLE.
- Latency per image: 4 cycles (LOAD through the first WAIT cycle), plus wrapper compute time, plus 1 (CAPT), plus GAP.
- Buffer read: combinational, always available, including while busy. rd_idx >= IMAGES returns 4'hF.
- Reset asserted mid-pass:
  - FSM goes immediately to IDLE; pulses go high asynchronously.
  - Buffer reinitialises to 4'hF; no partial result strobe.
- ready rising in any state other than WAIT is ignored.

Decomposition:
- Package mnist_seq_pkg holds:
  - the state enum;
  - DIGIT_INVALID = 4'hF;
  - a one-hot-to-index decode function returning digit and error.
- One sub-module, onehot_decoder (NCLASS -> 4-bit index + err, purely combinational). It is reused by the display path that currently drives hex_connect.
- Result buffer: a register array inside the top module.

Test Plan:
- Normal pass, IMAGES=3: behavioural wrapper model raises ready 20 cycles after each start, with classes 10'b0000000100, 10'b0010000000, 10'b0000000001 -> three res_valid strobes with res_idx 0,1,2 and res_digit 2,7,0. done = 1, busy = 0. rd_digit at idx 0..2 = 2,7,0; rd_idx = 5 -> 4'hF.
- Pulse protocol: check each image has load_params low exactly 1 cycle, 1 cycle of both pulses high, then start_comp low exactly 1 cycle. Pulses never overlap.
- Stale ready: model holds ready high across images and pulses it low for 3 cycles before re-asserting -> capture happens only on the re-assert edge, never immediately after START.
- Bad classes: classes = 10'b0000000000, then 10'b0000100010 -> res_err = 1 with res_digit = 4'hF for both; buffer holds 4'hF.
- Timeout, TIMEOUT=50: ready never rises on image 1 -> timeout = 1 after 50 WAIT cycles, busy = 0, done = 0. buffer[0] holds a valid digit; buffer[1] = 4'hF.
- Reset in WAIT of image 2: all outputs return to reset values within the same cycle. A fresh run edge restarts from image_num = 0.

Source files
------------

// File: rtl/mnist_seq_pkg.sv
// mnist_seq_pkg: sequencer state encoding, invalid-digit code and one-hot decode helper
package mnist_seq_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, LGAP, START, WAIT, CAPT, GAP, DONE} state_t;
    localparam logic [3:0] DIGIT_INVALID = 4'hF;
    typedef struct packed {
        logic       err;
        logic [3:0] digit;
    } dec_t;
    function automatic dec_t onehot_decode(input logic [15:0] v);
        dec_t r;
        int   n;
        n = 0;
        r.digit = DIGIT_INVALID;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                n++;
                r.digit = 4'(i);
            end
        end
        r.err = (n != 1);
        if (r.err) r.digit = DIGIT_INVALID;
        return r;
    endfunction
endpackage

// File: rtl/mnist_image_sequencer_onehot_decoder.sv
// onehot_decoder: combinational one-hot class vector to digit index
//   classes in  NCLASS  one-hot vector (NCLASS <= 16)
//   digit   out 4       set bit position, 4'hF when not exactly one bit set
//   err     out 1       zero or multiple bits set
module onehot_decoder
    import mnist_seq_pkg::*;
#(
    parameter int NCLASS = 10
) (
    input  logic [NCLASS-1:0] classes,
    output logic [3:0]        digit,
    output logic              err
);
    dec_t d;
    assign d     = onehot_decode(16'(classes));
    assign digit = d.digit;
    assign err   = d.err;
endmodule

// File: rtl/mnist_image_sequencer.sv
// mnist_image_sequencer: runs every stored image through the MNIST wrapper and buffers the decoded digits
//   clk, reset                 clock, async active-high reset
//   run                        rising edge starts a pass over images 0..IMAGES-1
//   load_params, start_comp    active-low pulses to the wrapper; image_num selects the image
//   ready, classes             wrapper done flag and one-hot result
//   res_valid/idx/digit/err    per-image capture strobe and result
//   rd_idx, rd_digit           combinational result buffer read
//   busy, done, timeout        pass status; done/timeout sticky until next run edge
module mnist_image_sequencer
    import mnist_seq_pkg::*;
#(
    parameter int IMAGES     = 10,
    parameter int IDX_W      = 4,
    parameter int NCLASS     = 10,
    parameter int GAP_CYCLES = 5,
    parameter int TIMEOUT    = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              load_params,
    output logic              start_comp,
    output logic [IDX_W-1:0]  image_num,
    input  logic              ready,
    input  logic [NCLASS-1:0] classes,
    output logic              res_valid,
    output logic [IDX_W-1:0]  res_idx,
    output logic [3:0]        res_digit,
    output logic              res_err,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [3:0]        rd_digit,
    output logic              busy,
    output logic              done,
    output logic              timeout
);
    localparam int GAP_N = GAP_CYCLES < 1 ? 1 : GAP_CYCLES;
    localparam int WC_W  = $clog2(TIMEOUT + 1);
    localparam int GC_W  = $clog2(GAP_N + 1);

    state_t            state;
    logic              run_q;
    logic              ready_q;
    logic [WC_W-1:0]   wcnt;
    logic [GC_W-1:0]   gcnt;
    logic [3:0]        mem [2**IDX_W];
    logic [3:0]        dec_digit;
    logic              dec_err;

    onehot_decoder #(.NCLASS(NCLASS)) u_dec (
        .classes (classes),
        .digit   (dec_digit),
        .err     (dec_err)
    );

    assign rd_digit = (int'(rd_idx) < IMAGES) ? mem[rd_idx] : DIGIT_INVALID;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            run_q       <= 1'b0;
            ready_q     <= 1'b0;
            wcnt        <= '0;
            gcnt        <= '0;
            load_params <= 1'b1;
            start_comp  <= 1'b1;
            image_num   <= '0;
            res_valid   <= 1'b0;
            res_idx     <= '0;
            res_digit   <= DIGIT_INVALID;
            res_err     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            for (int i = 0; i < 2**IDX_W; i++) mem[i] <= DIGIT_INVALID;
        end else begin
            run_q     <= run;
            ready_q   <= ready;
            res_valid <= 1'b0;
            case (state)
                IDLE: if (run && !run_q) begin
                    state       <= LOAD;
                    load_params <= 1'b0;
                    image_num   <= '0;
                    busy        <= 1'b1;
                    done        <= 1'b0;
                    timeout     <= 1'b0;
                end
                LOAD: begin
                    load_params <= 1'b1;
                    state       <= LGAP;
                end
                LGAP: begin
                    start_comp <= 1'b0;
                    state      <= START;
                end
                START: begin
                    start_comp <= 1'b1;
                    wcnt       <= '0;
                    state      <= WAIT;
                end
                // only a fresh rising edge counts, so a ready level left over from the previous image is ignored
                WAIT: if (ready && !ready_q) begin
                    state          <= CAPT;
                    res_valid      <= 1'b1;
                    res_idx        <= image_num;
                    res_digit      <= dec_digit;
                    res_err        <= dec_err;
                    mem[image_num] <= dec_digit;
                end else if (wcnt == WC_W'(TIMEOUT - 1)) begin
                    timeout <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
                CAPT: begin
                    gcnt  <= '0;
                    state <= (image_num == IDX_W'(IMAGES - 1)) ? DONE : GAP;
                end
                GAP: if (gcnt == GC_W'(GAP_N - 1)) begin
                    image_num   <= image_num + IDX_W'(1);
                    load_params <= 1'b0;
                    state       <= LOAD;
                end else begin
                    gcnt <= gcnt + 1'b1;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
